csr_ex_ctrl: RTL and testbench

Exception/ERTN sequencer between the write-back stage and the CSR register file. It samples trap conditions, pending interrupts and `ertn` at WB, and picks one event by priority. It then issues a single-cycle commit pulse (`wb_ex` + ecode/esubcode/pc/vaddr, or `ertn_flush`) to the CSR file, holds the pipeline flushed, and delivers the redirect target to fetch over a valid/ready handshake.

---
 rtl/csr_ex_ctrl.sv | 125 ++++++++++++
 tb/tb_csr_ex_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_ex_ctrl.sv
// Exception/ERTN sequencer: picks one WB event by priority, pulses the CSR commit,
// holds the pipeline flushed and hands the redirect target to fetch.
//
// state    | meaning
// IDLE     | watching WB for a trap or ertn
// COMMIT   | one-cycle wb_ex / ertn_flush pulse, target latched
// REDIRECT | redirect_valid held until fetch accepts
module csr_ex_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic [31:0] ws_vaddr,
    input  logic        ws_ex_adef,
    input  logic        ws_ex_ine,
    input  logic        ws_ex_sys,
    input  logic        ws_ex_brk,
    input  logic        ws_ex_ale,
    input  logic        ws_ertn,
    input  logic [11:0] int_pending,
    input  logic        crmd_ie,
    input  logic [31:0] ex_entry,
    input  logic [31:0] era,
    output logic        ws_cancel,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_csr_pc,
    output logic [31:0] wb_vaddr,
    output logic        ertn_flush,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

    state_t      state;
    logic        ex_kind;
    logic        int_take;
    logic        any_ex;
    logic        trap;
    logic        ert;
    logic [5:0]  ecode_sel;
    logic [31:0] vaddr_sel;

    always_comb begin
        int_take  = ws_valid & crmd_ie & (|int_pending);
        any_ex    = ws_valid & (ws_ex_adef | ws_ex_ine | ws_ex_sys | ws_ex_brk | ws_ex_ale);
        trap      = int_take | any_ex;
        ert       = ws_valid & ws_ertn & ~trap;
        ecode_sel = 6'h00;
        vaddr_sel = 32'h0;
        if (int_take) begin
            ecode_sel = 6'h00;
        end else if (ws_ex_adef) begin
            ecode_sel = 6'h08;
            vaddr_sel = ws_pc;
        end else if (ws_ex_ine) begin
            ecode_sel = 6'h0D;
        end else if (ws_ex_sys) begin
            ecode_sel = 6'h0B;
        end else if (ws_ex_brk) begin
            ecode_sel = 6'h0C;
        end else if (ws_ex_ale) begin
            ecode_sel = 6'h09;
            vaddr_sel = ws_vaddr;
        end
    end

    // Interrupted instructions are cancelled too; they re-execute after ertn.
    assign ws_cancel   = (state == IDLE) & trap;
    assign wb_esubcode = 9'h000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ex_kind        <= 1'b0;
            wb_ex          <= 1'b0;
            ertn_flush     <= 1'b0;
            wb_ecode       <= 6'h00;
            wb_csr_pc      <= 32'h0;
            wb_vaddr       <= 32'h0;
            pipe_flush     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap | ert) begin
                        state      <= COMMIT;
                        ex_kind    <= trap;
                        wb_ex      <= trap;
                        ertn_flush <= ert;
                        wb_ecode   <= trap ? ecode_sel : 6'h00;
                        wb_csr_pc  <= ws_pc;
                        wb_vaddr   <= trap ? vaddr_sel : 32'h0;
                        pipe_flush <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                COMMIT: begin
                    state          <= REDIRECT;
                    wb_ex          <= 1'b0;
                    ertn_flush     <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= ex_kind ? ex_entry : era;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        pipe_flush     <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_ex_ctrl.sv
// Bench for csr_ex_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a cycles-since-event model.
module tb_csr_ex_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid;
    logic [31:0] ws_pc, ws_vaddr;
    logic        ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale, ws_ertn;
    logic [11:0] int_pending;
    logic        crmd_ie;
    logic [31:0] ex_entry, era;
    logic        ws_cancel, wb_ex, ertn_flush, pipe_flush, redirect_valid, busy;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_csr_pc, wb_vaddr, redirect_pc;
    logic        redirect_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    csr_ex_ctrl dut (
        .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_vaddr(ws_vaddr),
        .ws_ex_adef(ws_ex_adef), .ws_ex_ine(ws_ex_ine), .ws_ex_sys(ws_ex_sys),
        .ws_ex_brk(ws_ex_brk), .ws_ex_ale(ws_ex_ale), .ws_ertn(ws_ertn),
        .int_pending(int_pending), .crmd_ie(crmd_ie), .ex_entry(ex_entry), .era(era),
        .ws_cancel(ws_cancel), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_csr_pc(wb_csr_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .pipe_flush(pipe_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // age: 0 idle, 1 commit cycle, >=2 waiting for fetch to accept the redirect
    bit          armed = 0;
    bit          zero_chk = 0;
    int          age = 0;
    bit          m_trap;
    logic [5:0]  m_ecode;
    logic [31:0] m_pc, m_vaddr, m_target;

    function automatic bit ev_trap();
        return ws_valid && ((crmd_ie && int_pending != 0) || ws_ex_adef || ws_ex_ine ||
                            ws_ex_sys || ws_ex_brk || ws_ex_ale);
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            if (zero_chk) begin
                check("rst_wb_ex", wb_ex, 0);
                check("rst_ertn_flush", ertn_flush, 0);
                check("rst_pipe_flush", pipe_flush, 0);
                check("rst_redirect_valid", redirect_valid, 0);
                check("rst_redirect_pc", redirect_pc, 0);
                check("rst_wb_ecode", wb_ecode, 0);
                check("rst_wb_csr_pc", wb_csr_pc, 0);
                check("rst_wb_vaddr", wb_vaddr, 0);
                check("rst_busy", busy, 0);
            end
            check("m_ws_cancel", ws_cancel, (age == 0) && ev_trap());
            check("m_busy", busy, age != 0);
            check("m_pipe_flush", pipe_flush, age != 0);
            check("m_wb_ex", wb_ex, age == 1 && m_trap);
            check("m_ertn_flush", ertn_flush, age == 1 && !m_trap);
            check("m_redirect_valid", redirect_valid, age >= 2);
            if (age == 1 && m_trap) begin
                check("m_wb_ecode", wb_ecode, m_ecode);
                check("m_wb_esubcode", wb_esubcode, 0);
                check("m_wb_csr_pc", wb_csr_pc, m_pc);
                check("m_wb_vaddr", wb_vaddr, m_vaddr);
            end
            if (age >= 2) check("m_redirect_pc", redirect_pc, m_target);
        end
        // advance model to the state after the coming rising edge
        zero_chk = 0;
        if (reset) begin
            armed = 1;
            zero_chk = 1;
            age = 0;
        end else if (armed) begin
            if (age == 0) begin
                if (ev_trap()) begin
                    m_trap = 1;
                    m_pc = ws_pc;
                    m_vaddr = 0;
                    if (crmd_ie && int_pending != 0) m_ecode = 6'h00;
                    else if (ws_ex_adef) begin m_ecode = 6'h08; m_vaddr = ws_pc; end
                    else if (ws_ex_ine) m_ecode = 6'h0D;
                    else if (ws_ex_sys) m_ecode = 6'h0B;
                    else if (ws_ex_brk) m_ecode = 6'h0C;
                    else begin m_ecode = 6'h09; m_vaddr = ws_vaddr; end
                    age = 1;
                end else if (ws_valid && ws_ertn) begin
                    m_trap = 0;
                    age = 1;
                end
            end else if (age == 1) begin
                m_target = m_trap ? ex_entry : era;
                age = 2;
            end else begin
                age = redirect_ready ? 0 : age + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ws();
        ws_valid = 0; ws_ex_adef = 0; ws_ex_ine = 0; ws_ex_sys = 0;
        ws_ex_brk = 0; ws_ex_ale = 0; ws_ertn = 0; int_pending = 0;
    endtask

    // event present in T; returns at T+1 after the negedge (COMMIT sample point)
    task automatic fire();
        @(negedge clk);
        tick();
        clear_ws();
        @(negedge clk);
    endtask

    task automatic finish_redirect();
        tick();
        tick();
    endtask

    initial begin
        reset = 1; clear_ws(); crmd_ie = 0; ws_pc = 0; ws_vaddr = 0;
        ex_entry = 32'h1C008000; era = 32'h1C000104; redirect_ready = 1;
        tick(); tick(); tick();
        reset = 0;
        tick();

        // SYS trap
        ws_valid = 1; ws_ex_sys = 1; ws_pc = 32'h1C000100;
        @(negedge clk);
        check("sys_cancel", ws_cancel, 1);
        tick(); clear_ws();
        @(negedge clk);
        check("sys_wb_ex", wb_ex, 1);
        check("sys_ecode", wb_ecode, 32'h0B);
        check("sys_csr_pc", wb_csr_pc, 32'h1C000100);
        check("sys_flush_t1", pipe_flush, 1);
        tick();
        @(negedge clk);
        check("sys_redirect_pc", redirect_pc, 32'h1C008000);
        check("sys_redirect_valid", redirect_valid, 1);
        tick();
        @(negedge clk);
        check("sys_flush_t3", pipe_flush, 0);
        tick();

        // priority INE over ALE, then ALE alone
        ws_valid = 1; ws_ex_ine = 1; ws_ex_ale = 1; ws_vaddr = 32'h1003;
        fire();
        check("ine_ecode", wb_ecode, 32'h0D);
        check("ine_vaddr", wb_vaddr, 0);
        finish_redirect();
        ws_valid = 1; ws_ex_ale = 1;
        fire();
        check("ale_ecode", wb_ecode, 32'h09);
        check("ale_vaddr", wb_vaddr, 32'h1003);
        finish_redirect();

        // interrupt beats BRK and ertn; masked by crmd_ie=0
        crmd_ie = 1;
        ws_valid = 1; ws_ex_brk = 1; int_pending = 12'h004;
        fire();
        check("int_brk_ecode", wb_ecode, 0);
        check("int_brk_wb_ex", wb_ex, 1);
        finish_redirect();
        ws_valid = 1; ws_ertn = 1; int_pending = 12'h004;
        fire();
        check("int_ertn_ecode", wb_ecode, 0);
        check("int_ertn_flush", ertn_flush, 0);
        finish_redirect();
        crmd_ie = 0;
        ws_valid = 1; ws_ex_brk = 1; int_pending = 12'h004;
        fire();
        check("brk_ecode", wb_ecode, 32'h0C);
        finish_redirect();
        ws_valid = 1; ws_ertn = 1; int_pending = 12'h004;
        @(negedge clk);
        check("ertn_cancel", ws_cancel, 0);
        tick(); clear_ws();
        @(negedge clk);
        check("ertn_flush", ertn_flush, 1);
        check("ertn_wb_ex", wb_ex, 0);
        tick();
        @(negedge clk);
        check("ertn_redirect_pc", redirect_pc, 32'h1C000104);
        tick();

        // backpressure with a flushed SYS during the stall
        redirect_ready = 0;
        ws_valid = 1; ws_ex_sys = 1; ws_pc = 32'h1C000300;
        fire();
        tick();
        for (int i = 0; i < 5; i++) begin
            ws_valid = i[0]; ws_ex_sys = 1;
            @(negedge clk);
            check("bp_valid", redirect_valid, 1);
            check("bp_pc", redirect_pc, 32'h1C008000);
            check("bp_flush", pipe_flush, 1);
            check("bp_no_wb_ex", wb_ex, 0);
            tick();
        end
        clear_ws();
        redirect_ready = 1;
        tick(); tick();

        // reset in COMMIT, then ADEF
        ws_valid = 1; ws_ex_brk = 1;
        fire();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check("mid_rst_wb_ex", wb_ex, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_redirect_valid", redirect_valid, 0);
        tick();
        ws_valid = 1; ws_ex_adef = 1; ws_ex_ale = 1; ws_pc = 32'h1C000200;
        fire();
        check("adef_ecode", wb_ecode, 32'h08);
        check("adef_vaddr", wb_vaddr, 32'h1C000200);
        finish_redirect();

        // randomized run, checked by the model
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            ws_valid    = $urandom_range(0, 1);
            ws_pc       = $urandom;
            ws_vaddr    = $urandom;
            ws_ex_adef  = ($urandom_range(0, 9) == 0);
            ws_ex_ine   = ($urandom_range(0, 9) == 0);
            ws_ex_sys   = ($urandom_range(0, 9) == 0);
            ws_ex_brk   = ($urandom_range(0, 9) == 0);
            ws_ex_ale   = ($urandom_range(0, 9) == 0);
            ws_ertn     = ($urandom_range(0, 4) == 0);
            int_pending = ($urandom_range(0, 5) == 0) ? 12'($urandom) : 12'h0;
            crmd_ie     = $urandom_range(0, 1);
            ex_entry    = $urandom;
            era         = $urandom;
            redirect_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        reset = 0;
        clear_ws();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
